// File: rtl/lc3_fetch_ir.sv
// LC-3 instruction fetch and instruction register.
// Reads the word at PC, latches it into IR, advances PC and holds the
// instruction until the decoder acknowledges it. Also presents the raw IR
// fields consumed by the sign-extension blocks and the register file.
module lc3_fetch_ir #(
   parameter logic [15:0] PC_RESET   = 16'h3000,
   parameter int unsigned WAIT_LIMIT = 64
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FETCH_EN,
   input  logic        LD_PC,
   input  logic [15:0] PC_IN,
   output logic [15:0] MEM_ADDR,
   output logic        MEM_RD,
   input  logic        MEM_RDY,
   input  logic [15:0] MEM_DATA,
   output logic        MEM_ERR,
   output logic [15:0] IR,
   output logic        IR_VALID,
   input  logic        IR_ACK,
   output logic [15:0] PC,
   output logic        BUSY,
   output logic [3:0]  OPCODE,
   output logic [2:0]  DR,
   output logic [2:0]  SR1,
   output logic [2:0]  SR2,
   output logic [10:0] IR_10_0,
   output logic [8:0]  IR_8_0,
   output logic [5:0]  IR_5_0,
   output logic [4:0]  IR_4_0
);

   localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state;
   logic [7:0]  cnt;
   logic        pend;
   logic [15:0] pend_pc;
   logic        redirect;
   logic [15:0] redirect_pc;

   // A redirect strobe arriving in the same cycle as the fetch ends still
   // counts, so the live strobe overrides any earlier latched target.
   always_comb begin
      redirect    = pend | LD_PC;
      redirect_pc = LD_PC ? PC_IN : pend_pc;
   end

   // Fetch sequencer: IDLE -> REQ (memory read) -> HOLD (IR held for decoder)
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         PC       <= PC_RESET;
         MEM_ADDR <= PC_RESET;
         MEM_RD   <= 1'b0;
         MEM_ERR  <= 1'b0;
         IR       <= '0;
         IR_VALID <= 1'b0;
         cnt      <= '0;
         pend     <= 1'b0;
         pend_pc  <= '0;
      end else begin
         MEM_ERR <= 1'b0;
         case (state)
            IDLE: begin
               if (LD_PC) begin
                  PC <= PC_IN;
               end else if (FETCH_EN) begin
                  MEM_ADDR <= PC;
                  PC       <= PC + 16'd1;
                  MEM_RD   <= 1'b1;
                  cnt      <= '0;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (LD_PC) begin
                  pend    <= 1'b1;
                  pend_pc <= PC_IN;
               end
               if (MEM_RDY) begin
                  MEM_RD <= 1'b0;
                  if (redirect) begin
                     // Stale word from the old flow: drop it and jump.
                     PC    <= redirect_pc;
                     pend  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     IR       <= MEM_DATA;
                     IR_VALID <= 1'b1;
                     state    <= HOLD;
                  end
               end else if (cnt == CNT_LAST) begin
                  // Give up; rewind PC so the same word is refetched.
                  MEM_RD  <= 1'b0;
                  MEM_ERR <= 1'b1;
                  PC      <= redirect ? redirect_pc : MEM_ADDR;
                  pend    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            HOLD: begin
               if (LD_PC) begin
                  PC <= PC_IN;
               end
               if (IR_ACK) begin
                  IR_VALID <= 1'b0;
                  if (FETCH_EN && !LD_PC) begin
                     MEM_ADDR <= PC;
                     PC       <= PC + 16'd1;
                     MEM_RD   <= 1'b1;
                     cnt      <= '0;
                     state    <= REQ;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               MEM_RD <= 1'b0;
            end
         endcase
      end
   end

   // Raw IR fields and busy flag
   always_comb begin
      BUSY    = (state != IDLE);
      OPCODE  = IR[15:12];
      DR      = IR[11:9];
      SR1     = IR[8:6];
      SR2     = IR[2:0];
      IR_10_0 = IR[10:0];
      IR_8_0  = IR[8:0];
      IR_5_0  = IR[5:0];
      IR_4_0  = IR[4:0];
   end

endmodule

// File: tb/tb_lc3_fetch_ir.sv
// Directed self-checking bench for lc3_fetch_ir.
module tb_lc3_fetch_ir;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        FETCH_EN = 1'b0;
   logic        LD_PC = 1'b0;
   logic [15:0] PC_IN = '0;
   logic [15:0] MEM_ADDR;
   logic        MEM_RD;
   logic        MEM_RDY = 1'b0;
   logic [15:0] MEM_DATA = '0;
   logic        MEM_ERR;
   logic [15:0] IR;
   logic        IR_VALID;
   logic        IR_ACK = 1'b0;
   logic [15:0] PC;
   logic        BUSY;
   logic [3:0]  OPCODE;
   logic [2:0]  DR, SR1, SR2;
   logic [10:0] IR_10_0;
   logic [8:0]  IR_8_0;
   logic [5:0]  IR_5_0;
   logic [4:0]  IR_4_0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   lc3_fetch_ir #(.PC_RESET(16'h3000), .WAIT_LIMIT(4)) dut (
      .CLK(CLK), .RESET(RESET), .FETCH_EN(FETCH_EN), .LD_PC(LD_PC),
      .PC_IN(PC_IN), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_RDY(MEM_RDY),
      .MEM_DATA(MEM_DATA), .MEM_ERR(MEM_ERR), .IR(IR), .IR_VALID(IR_VALID),
      .IR_ACK(IR_ACK), .PC(PC), .BUSY(BUSY), .OPCODE(OPCODE), .DR(DR),
      .SR1(SR1), .SR2(SR2), .IR_10_0(IR_10_0), .IR_8_0(IR_8_0),
      .IR_5_0(IR_5_0), .IR_4_0(IR_4_0)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick(); tick();
      RESET = 1'b0;
      tick();
      check("rst_pc", 32'(PC), 32'h3000);
      check("rst_addr", 32'(MEM_ADDR), 32'h3000);
      check("rst_ir", 32'(IR), 32'h0);
      check("rst_irv", 32'(IR_VALID), 32'h0);
      check("rst_rd", 32'(MEM_RD), 32'h0);
      check("rst_err", 32'(MEM_ERR), 32'h0);
      check("rst_busy", 32'(BUSY), 32'h0);

      // single fetch with two wait cycles
      FETCH_EN = 1'b1;
      tick();
      FETCH_EN = 1'b0;
      check("f1_rd", 32'(MEM_RD), 32'h1);
      check("f1_addr", 32'(MEM_ADDR), 32'h3000);
      check("f1_pc", 32'(PC), 32'h3001);
      check("f1_busy", 32'(BUSY), 32'h1);
      tick();
      check("f1_wait_rd", 32'(MEM_RD), 32'h1);
      check("f1_wait_addr", 32'(MEM_ADDR), 32'h3000);
      tick();
      MEM_RDY = 1'b1; MEM_DATA = 16'h1261;
      tick();
      MEM_RDY = 1'b0; MEM_DATA = 16'hDEAD;
      check("f1_ir", 32'(IR), 32'h1261);
      check("f1_irv", 32'(IR_VALID), 32'h1);
      check("f1_rd_off", 32'(MEM_RD), 32'h0);
      check("f1_pc2", 32'(PC), 32'h3001);
      check("f1_op", 32'(OPCODE), 32'h1);
      check("f1_dr", 32'(DR), 32'h1);
      check("f1_sr1", 32'(SR1), 32'h1);
      check("f1_sr2", 32'(SR2), 32'h1);
      check("f1_i10", 32'(IR_10_0), 32'h261);
      check("f1_i8", 32'(IR_8_0), 32'h061);
      check("f1_i5", 32'(IR_5_0), 32'h21);
      check("f1_i4", 32'(IR_4_0), 32'h01);

      // FETCH_EN without ack in HOLD is ignored; late MEM_RDY ignored
      FETCH_EN = 1'b1; MEM_RDY = 1'b1;
      tick();
      MEM_RDY = 1'b0;
      check("hold_irv", 32'(IR_VALID), 32'h1);
      check("hold_rd", 32'(MEM_RD), 32'h0);
      check("hold_ir", 32'(IR), 32'h1261);

      // back-to-back fetch
      IR_ACK = 1'b1;
      tick();
      IR_ACK = 1'b0; FETCH_EN = 1'b0;
      check("b2b_rd", 32'(MEM_RD), 32'h1);
      check("b2b_addr", 32'(MEM_ADDR), 32'h3001);
      check("b2b_pc", 32'(PC), 32'h3002);
      check("b2b_irv", 32'(IR_VALID), 32'h0);
      MEM_RDY = 1'b1; MEM_DATA = 16'h5A3F;
      tick();
      MEM_RDY = 1'b0;
      check("b2b_ir", 32'(IR), 32'h5A3F);
      check("b2b_op", 32'(OPCODE), 32'h5);
      check("b2b_dr", 32'(DR), 32'h5);
      check("b2b_irv2", 32'(IR_VALID), 32'h1);

      // ack without fetch returns to IDLE
      IR_ACK = 1'b1;
      tick();
      IR_ACK = 1'b0;
      check("ack_busy", 32'(BUSY), 32'h0);
      check("ack_irv", 32'(IR_VALID), 32'h0);
      check("ack_ir", 32'(IR), 32'h5A3F);

      // redirect during REQ
      FETCH_EN = 1'b1;
      tick();
      FETCH_EN = 1'b0;
      check("rd_addr", 32'(MEM_ADDR), 32'h3002);
      LD_PC = 1'b1; PC_IN = 16'h4000;
      tick();
      LD_PC = 1'b0; PC_IN = 16'h0000;
      check("rd_pc_hold", 32'(PC), 32'h3003);
      check("rd_rd_hold", 32'(MEM_RD), 32'h1);
      MEM_RDY = 1'b1; MEM_DATA = 16'hFFFF;
      tick();
      MEM_RDY = 1'b0;
      check("rd_ir", 32'(IR), 32'h5A3F);
      check("rd_irv", 32'(IR_VALID), 32'h0);
      check("rd_pc", 32'(PC), 32'h4000);
      check("rd_busy", 32'(BUSY), 32'h0);
      check("rd_rd", 32'(MEM_RD), 32'h0);
      FETCH_EN = 1'b1;
      tick();
      FETCH_EN = 1'b0;
      check("rd2_addr", 32'(MEM_ADDR), 32'h4000);
      check("rd2_pc", 32'(PC), 32'h4001);
      MEM_RDY = 1'b1; MEM_DATA = 16'h1234;
      tick();
      MEM_RDY = 1'b0;
      check("rd2_ir", 32'(IR), 32'h1234);
      IR_ACK = 1'b1;
      tick();
      IR_ACK = 1'b0;

      // timeout: four REQ cycles without MEM_RDY
      FETCH_EN = 1'b1;
      tick();
      FETCH_EN = 1'b0;
      check("to_addr", 32'(MEM_ADDR), 32'h4001);
      check("to_pc0", 32'(PC), 32'h4002);
      tick(); tick(); tick();
      check("to_rd_pre", 32'(MEM_RD), 32'h1);
      check("to_err_pre", 32'(MEM_ERR), 32'h0);
      tick();
      check("to_err", 32'(MEM_ERR), 32'h1);
      check("to_rd", 32'(MEM_RD), 32'h0);
      check("to_pc", 32'(PC), 32'h4001);
      check("to_busy", 32'(BUSY), 32'h0);
      tick();
      check("to_err_off", 32'(MEM_ERR), 32'h0);

      // wrap: LD_PC beats FETCH_EN in IDLE, then fetch at FFFF
      LD_PC = 1'b1; PC_IN = 16'hFFFF; FETCH_EN = 1'b1;
      tick();
      LD_PC = 1'b0;
      check("wr_pc", 32'(PC), 32'hFFFF);
      check("wr_idle", 32'(MEM_RD), 32'h0);
      tick();
      FETCH_EN = 1'b0;
      check("wr_addr", 32'(MEM_ADDR), 32'hFFFF);
      check("wr_pc2", 32'(PC), 32'h0000);

      // LD_PC coincident with MEM_RDY discards the data
      LD_PC = 1'b1; PC_IN = 16'h0100; MEM_RDY = 1'b1; MEM_DATA = 16'hBEEF;
      tick();
      LD_PC = 1'b0; MEM_RDY = 1'b0;
      check("co_pc", 32'(PC), 32'h0100);
      check("co_ir", 32'(IR), 32'h1234);
      check("co_irv", 32'(IR_VALID), 32'h0);

      // asynchronous reset in the middle of REQ
      FETCH_EN = 1'b1;
      tick();
      FETCH_EN = 1'b0;
      check("ar_pre_rd", 32'(MEM_RD), 32'h1);
      #2;
      RESET = 1'b1;
      #1;
      check("ar_pc", 32'(PC), 32'h3000);
      check("ar_rd", 32'(MEM_RD), 32'h0);
      check("ar_irv", 32'(IR_VALID), 32'h0);
      check("ar_ir", 32'(IR), 32'h0);
      check("ar_busy", 32'(BUSY), 32'h0);
      tick();
      RESET = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
